// File: rtl/rob_buffer_pkg.sv
// Shared types and sizing for the reorder buffer (package rob_pkg).
// Entries are either free, allocated but still waiting for a result,
// or finished and ready to retire.
package rob_pkg;

    localparam int ROB_DEPTH  = 16;
    localparam int ROB_IDX_W  = 4;
    localparam int ROB_DATA_W = 8;
    localparam int ROB_CNT_W  = ROB_IDX_W + 1;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        ISSUED = 2'd1,
        DONE   = 2'd2
    } rob_state_t;

    typedef struct packed {
        rob_state_t              state;
        logic [ROB_DATA_W-1:0]   flags;
        logic [ROB_DATA_W-1:0]   wbs;
        logic [ROB_DATA_W-1:0]   value;
    } rob_entry_t;

    // Circular pointer advance; the natural 4-bit overflow gives the 15->0 wrap.
    function automatic logic [ROB_IDX_W-1:0] idx_inc(input logic [ROB_IDX_W-1:0] idx);
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/rob_buffer_if.sv
// Bundle of dispatch, write-back, retire and status signals of the ROB.
// master: the surrounding pipeline; slave: the ROB itself.
// The flush pulse exists only when ROB_FLUSH_EN is defined.
interface rob_buffer_if
    import rob_pkg::*;
#(
    parameter int DATA_W = ROB_DATA_W
);
    logic                  alloc_valid;
    logic                  alloc_ready;
    logic [ROB_IDX_W-1:0]  alloc_robid;

    logic                  wb_valid;
    logic [ROB_IDX_W-1:0]  wb_robid;
    logic [DATA_W-1:0]     wb_flags;
    logic [DATA_W-1:0]     wb_wbs;
    logic [DATA_W-1:0]     wb_value;

    logic                  commit_valid;
    logic                  commit_ready;
    logic [ROB_IDX_W-1:0]  commit_robid;
    logic [DATA_W-1:0]     commit_flags;
    logic [DATA_W-1:0]     commit_wbs;
    logic [DATA_W-1:0]     commit_value;

    logic [ROB_CNT_W-1:0]  count;
    logic                  full;
    logic                  empty;
    logic                  wb_err;
`ifdef ROB_FLUSH_EN
    logic                  flush;
`endif

    modport master (
        output alloc_valid,
        input  alloc_ready, alloc_robid,
        output wb_valid, wb_robid, wb_flags, wb_wbs, wb_value,
        input  commit_valid,
        output commit_ready,
        input  commit_robid, commit_flags, commit_wbs, commit_value,
`ifdef ROB_FLUSH_EN
        input  flush,
`endif
        input  count, full, empty, wb_err
    );

    modport slave (
        input  alloc_valid,
        output alloc_ready, alloc_robid,
        input  wb_valid, wb_robid, wb_flags, wb_wbs, wb_value,
        output commit_valid,
        input  commit_ready,
        output commit_robid, commit_flags, commit_wbs, commit_value,
`ifdef ROB_FLUSH_EN
        output flush,
`endif
        output count, full, empty, wb_err
    );

endinterface

// File: rtl/rob_buffer.sv
// Reorder buffer: in-order allocation and retirement, out-of-order
// write-back. Optional feature macro: ROB_FLUSH_EN (commit of an entry
// with flags[7] set frees the whole buffer and pulses flush).
module rob_buffer
    import rob_pkg::*;
#(
    parameter int DEPTH  = ROB_DEPTH,
    parameter int DATA_W = ROB_DATA_W
)(
    input  logic         clk,
    input  logic         rst_n,
    rob_buffer_if.slave  bus
);

    rob_state_t            st        [DEPTH];
    logic [DATA_W-1:0]     flags_mem [DEPTH];
    logic [DATA_W-1:0]     wbs_mem   [DEPTH];
    logic [DATA_W-1:0]     val_mem   [DEPTH];

    logic [ROB_IDX_W-1:0]  head;
    logic [ROB_IDX_W-1:0]  tail;
    logic [ROB_CNT_W-1:0]  count;
    logic                  wb_err;

    rob_entry_t            head_view;
    logic                  full;
    logic                  empty;
    logic                  cvalid;
    logic                  aready;
    logic                  do_alloc;
    logic                  do_commit;
    logic                  wb_is_issued;
    logic                  wb_quiet;
    logic                  wb_hit;
    logic                  wb_miss;
`ifdef ROB_FLUSH_EN
    logic                  flush_q;
    logic                  flush_now;
`endif

    // Head entry view, occupancy and handshake decisions for this cycle.
    always_comb begin
        head_view = '{state: st[head], flags: flags_mem[head],
                      wbs: wbs_mem[head], value: val_mem[head]};
        full      = (count == ROB_CNT_W'(DEPTH));
        empty     = (count == '0);
        cvalid    = (head_view.state == DONE);
        do_commit = cvalid & bus.commit_ready;
`ifdef ROB_FLUSH_EN
        // Hold off dispatch while a flushing entry sits at the head so no
        // freshly granted id is wiped by the flush.
        aready    = ~full & ~(cvalid & head_view.flags[7]);
        flush_now = do_commit & head_view.flags[7];
        wb_quiet  = flush_now | flush_q;
`else
        aready    = ~full;
        wb_quiet  = 1'b0;
`endif
        do_alloc     = bus.alloc_valid & aready;
        // Judged on pre-edge state: a same-cycle alloc of this index still sees FREE.
        wb_is_issued = (st[bus.wb_robid] == ISSUED);
        wb_hit       = bus.wb_valid & wb_is_issued & ~wb_quiet;
        wb_miss      = bus.wb_valid & ~wb_is_issued & ~wb_quiet;
    end

    // Entry states, pointers, occupancy and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                st[i] <= FREE;
            end
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            wb_err <= 1'b0;
`ifdef ROB_FLUSH_EN
            flush_q <= 1'b0;
`endif
        end else begin
            if (wb_miss) begin
                wb_err <= 1'b1;
            end
`ifdef ROB_FLUSH_EN
            flush_q <= flush_now;
            if (flush_now) begin
                for (int i = 0; i < DEPTH; i++) begin
                    st[i] <= FREE;
                end
                head  <= idx_inc(head);
                tail  <= idx_inc(head);
                count <= '0;
            end else begin
`else
            begin
`endif
                if (do_alloc) begin
                    st[tail] <= ISSUED;
                    tail     <= idx_inc(tail);
                end
                if (wb_hit) begin
                    st[bus.wb_robid] <= DONE;
                end
                if (do_commit) begin
                    st[head] <= FREE;
                    head     <= idx_inc(head);
                end
                case ({do_alloc, do_commit})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Result payload storage; never reset, masked at the outputs instead.
    always_ff @(posedge clk) begin
        if (wb_hit) begin
            flags_mem[bus.wb_robid] <= bus.wb_flags;
            wbs_mem[bus.wb_robid]   <= bus.wb_wbs;
            val_mem[bus.wb_robid]   <= bus.wb_value;
        end
    end

    assign bus.alloc_ready  = aready;
    assign bus.alloc_robid  = tail;
    assign bus.commit_valid = cvalid;
    assign bus.commit_robid = cvalid ? head            : '0;
    assign bus.commit_flags = cvalid ? head_view.flags : '0;
    assign bus.commit_wbs   = cvalid ? head_view.wbs   : '0;
    assign bus.commit_value = cvalid ? head_view.value : '0;
    assign bus.count        = count;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.wb_err       = wb_err;
`ifdef ROB_FLUSH_EN
    assign bus.flush        = flush_q;
`endif

endmodule

// File: tb/tb_rob_buffer.sv
// Bench for rob_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rob_buffer;
    import rob_pkg::*;

`ifdef ROB_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rob_buffer_if #(.DATA_W(8)) rif ();

    rob_buffer #(.DEPTH(16), .DATA_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (rif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int       q[$];          // ids in allocation order; q[0] is the head
    int       m_st [16];     // 0 free, 1 issued, 2 done
    bit [7:0] m_fl [16];
    bit [7:0] m_wb [16];
    bit [7:0] m_val[16];
    int       m_tail;
    bit       m_err;
    bit       m_flush;

    function automatic bit e_cv();
        return (q.size() > 0) && (m_st[q[0]] == 2);
    endfunction

    function automatic bit e_ready();
        bit r;
        r = (q.size() < 16);
        if (FLUSH_EN && e_cv() && m_fl[q[0]][7]) r = 1'b0;
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            for (int i = 0; i < 16; i++) m_st[i] = 0;
            m_tail  = 0;
            m_err   = 0;
            m_flush = 0;
        end else begin
            bit cv, ar, da, dc, fl_now, quiet, wb_ok;
            int wid;
            cv     = e_cv();
            ar     = e_ready();
            da     = rif.alloc_valid && ar;
            dc     = rif.commit_ready && cv;
            fl_now = FLUSH_EN && dc && m_fl[q[0]][7];
            quiet  = fl_now || m_flush;
            wid    = int'(rif.wb_robid);
            wb_ok  = 1'b0;
            if (rif.wb_valid && !quiet) begin
                if (m_st[wid] == 1) wb_ok = 1'b1;
                else m_err = 1'b1;
            end
            if (fl_now) begin
                m_tail = (q[0] + 1) % 16;
                q.delete();
                for (int i = 0; i < 16; i++) m_st[i] = 0;
                m_flush = 1'b1;
            end else begin
                m_flush = 1'b0;
                if (wb_ok) begin
                    m_st[wid]  = 2;
                    m_fl[wid]  = rif.wb_flags;
                    m_wb[wid]  = rif.wb_wbs;
                    m_val[wid] = rif.wb_value;
                end
                if (dc) begin
                    m_st[q[0]] = 0;
                    void'(q.pop_front());
                end
                if (da) begin
                    m_st[m_tail] = 1;
                    q.push_back(m_tail);
                    m_tail = (m_tail + 1) % 16;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            bit cv;
            cv = e_cv();
            chk("alloc_ready",  rif.alloc_ready,  e_ready());
            chk("alloc_robid",  rif.alloc_robid,  m_tail);
            chk("count",        rif.count,        q.size());
            chk("full",         rif.full,         q.size() == 16);
            chk("empty",        rif.empty,        q.size() == 0);
            chk("wb_err",       rif.wb_err,       m_err);
            chk("commit_valid", rif.commit_valid, cv);
            chk("commit_robid", rif.commit_robid, cv ? q[0] : 0);
            chk("commit_flags", rif.commit_flags, cv ? m_fl[q[0]] : 0);
            chk("commit_wbs",   rif.commit_wbs,   cv ? m_wb[q[0]] : 0);
            chk("commit_value", rif.commit_value, cv ? m_val[q[0]] : 0);
`ifdef ROB_FLUSH_EN
            chk("flush",        rif.flush,        m_flush);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rif.alloc_valid  = 1'b0;
        rif.wb_valid     = 1'b0;
        rif.commit_ready = 1'b0;
        rif.wb_robid     = '0;
        rif.wb_flags     = '0;
        rif.wb_wbs       = '0;
        rif.wb_value     = '0;
    endtask

    task automatic do_reset();
        idle();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk("rst_count",        rif.count,        0);
        chk("rst_commit_valid", rif.commit_valid, 0);
        chk("rst_wb_err",       rif.wb_err,       0);
        chk("rst_alloc_ready",  rif.alloc_ready,  1);
        chk("rst_alloc_robid",  rif.alloc_robid,  0);
        step();
        rst_n = 1'b1;
    endtask

    task automatic wb(input int id, input logic [7:0] fl, input logic [7:0] v);
        rif.wb_valid = 1'b1;
        rif.wb_robid = 4'(id);
        rif.wb_flags = fl;
        rif.wb_wbs   = 8'(id + 8'h40);
        rif.wb_value = v;
        step();
        rif.wb_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle();
        do_reset();

        // Sixteen allocations without write-back fill the buffer.
        rif.alloc_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("fill_robid", rif.alloc_robid, i);
            step();
        end
        rif.alloc_valid = 1'b0;
        chk("fill_count",        rif.count,        16);
        chk("fill_alloc_ready",  rif.alloc_ready,  0);
        chk("fill_commit_valid", rif.commit_valid, 0);
        chk("fill_full",         rif.full,         1);

        // Full: complete head, then commit and alloc together.
        wb(0, 8'h01, 8'h5A);
        chk("full_head_valid", rif.commit_valid, 1);
        chk("full_head_value", rif.commit_value, 8'h5A);
        rif.alloc_valid  = 1'b1;
        rif.commit_ready = 1'b1;
        chk("full_alloc_ready", rif.alloc_ready, 0);
        step();
        idle();
        chk("full_after_count", rif.count,       15);
        chk("full_after_robid", rif.alloc_robid, 0);
        chk("full_after_ready", rif.alloc_ready, 1);

        // Out-of-order write-back, in-order commit.
        do_reset();
        rif.alloc_valid = 1'b1;
        repeat (3) step();
        rif.alloc_valid = 1'b0;
        wb(2, 8'h00, 8'h33);
        chk("ooo_no_commit", rif.commit_valid, 0);
        wb(1, 8'h00, 8'h22);
        wb(0, 8'h00, 8'h11);
        rif.commit_ready = 1'b1;
        chk("ooo_c0_id",  rif.commit_robid, 0);
        chk("ooo_c0_val", rif.commit_value, 8'h11);
        step();
        chk("ooo_c1_id",  rif.commit_robid, 1);
        chk("ooo_c1_val", rif.commit_value, 8'h22);
        step();
        chk("ooo_c2_id",  rif.commit_robid, 2);
        chk("ooo_c2_val", rif.commit_value, 8'h33);
        chk("ooo_c2_wbs", rif.commit_wbs,   8'h42);
        step();
        rif.commit_ready = 1'b0;
        chk("ooo_empty", rif.count, 0);
        chk("ooo_cv_empty", rif.commit_valid, 0);

        // Write-back to a free entry.
        wb(5, 8'h00, 8'hAA);
        chk("free_wb_err",   rif.wb_err,       1);
        chk("free_wb_cv",    rif.commit_valid, 0);
        chk("free_wb_value", rif.commit_value, 0);
        chk("free_wb_count", rif.count,        0);
        repeat (3) step();
        chk("free_wb_sticky", rif.wb_err, 1);

        // Alloc and write-back to the same index in one cycle.
        do_reset();
        rif.alloc_valid = 1'b1;
        rif.wb_valid    = 1'b1;
        rif.wb_robid    = 4'd0;
        rif.wb_value    = 8'h77;
        step();
        idle();
        chk("same_err",   rif.wb_err,       1);
        chk("same_count", rif.count,        1);
        chk("same_cv",    rif.commit_valid, 0);
        wb(0, 8'h00, 8'h99);
        chk("same_cv2",  rif.commit_valid, 1);
        chk("same_val2", rif.commit_value, 8'h99);

        // Mixed traffic, model-checked every cycle.
        do_reset();
        for (int c = 0; c < 300; c++) begin
            int pend[$];
            idle();
            rif.alloc_valid  = ($urandom_range(0, 3) != 0);
            rif.commit_ready = ($urandom_range(0, 2) != 0);
            foreach (q[k]) if (m_st[q[k]] == 1) pend.push_back(q[k]);
            if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
                rif.wb_valid = 1'b1;
                rif.wb_robid = 4'(pend[$urandom_range(0, pend.size() - 1)]);
                rif.wb_flags = 8'($urandom_range(0, 127));
                rif.wb_wbs   = 8'($urandom_range(0, 255));
                rif.wb_value = 8'($urandom_range(0, 255));
            end
            step();
        end
        idle();
        step();

`ifdef ROB_FLUSH_EN
        // Flush on commit of an entry whose flags[7] is set.
        do_reset();
        rif.alloc_valid = 1'b1;
        repeat (4) step();
        rif.alloc_valid = 1'b0;
        wb(0, 8'h00, 8'h10);
        wb(1, 8'h80, 8'h11);
        wb(2, 8'h00, 8'h12);
        wb(3, 8'h00, 8'h13);
        rif.commit_ready = 1'b1;
        chk("fl_c0_id", rif.commit_robid, 0);
        step();
        chk("fl_c1_id",    rif.commit_robid, 1);
        chk("fl_c1_flags", rif.commit_flags, 8'h80);
        chk("fl_ready_lo", rif.alloc_ready,  0);
        step();
        rif.commit_ready = 1'b0;
        chk("fl_pulse", rif.flush,        1);
        chk("fl_count", rif.count,        0);
        chk("fl_robid", rif.alloc_robid,  2);
        chk("fl_cv",    rif.commit_valid, 0);
        step();
        chk("fl_pulse_end", rif.flush, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rob_buffer.md
ROB_BUFFER -- requirements
Module: rob_buffer

Interface
REQ-001 Parameter DEPTH, default 16, entry count; SHALL equal 2**ROB_IDX_W.
REQ-002 Parameter DATA_W, default 8, width of value, flags and wbs fields.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 alloc_valid  input  1  dispatch requests one entry.
REQ-006 alloc_ready  output  1  entry available this cycle.
REQ-007 alloc_robid  output  4  index granted; equals the tail pointer.
REQ-008 wb_valid  input  1  result write from the functional-unit ROB chain.
REQ-009 wb_robid / wb_flags / wb_wbs / wb_value  input  4/8/8/8  write-back payload.
REQ-010 commit_valid  output  1  head entry complete.
REQ-011 commit_ready  input  1  retire sink accepts the head.
REQ-012 commit_robid / commit_flags / commit_wbs / commit_value  output  4/8/8/8  head payload.
REQ-013 count  output  5  occupied entries, 0..16; full and empty outputs (1 bit each) derived from it.
REQ-014 wb_err  output  1  sticky; set by an illegal write-back.
REQ-015 flush  output  1  one-cycle pulse (exists only under ROB_FLUSH_EN).

Function
REQ-016 The buffer SHALL be circular, with 4-bit head and tail pointers that wrap from 15 to 0.
REQ-017 Each entry SHALL hold one state: FREE, ISSUED or DONE.
- FREE->ISSUED on alloc.
- ISSUED->DONE on write-back.
- DONE->FREE on commit.
REQ-018 alloc_ready SHALL be ~full, gated by REQ-030 when configured.
- On alloc_valid & alloc_ready: entry[tail] goes to ISSUED; tail increments.
REQ-019 On wb_valid where entry[wb_robid] is ISSUED, the entry SHALL store flags, wbs and value and become DONE at the next edge.
REQ-020 On wb_valid where entry[wb_robid] is FREE or DONE:
- The write SHALL be ignored.
- wb_err SHALL be set and held until reset.
REQ-021 commit_valid SHALL be the combinational result of entry[head] being DONE; write-back to the head gives commit_valid one cycle later.
REQ-022 On commit_valid & commit_ready, entry[head] SHALL become FREE and head SHALL increment.
REQ-023 While commit_valid is low, all commit_* payload outputs SHALL be driven to 0.
REQ-024 count SHALL change as follows: +1 on alloc, -1 on commit, unchanged when both occur in the same cycle.
REQ-025 When full (count==16), simultaneous commit and alloc_valid SHALL NOT allocate; alloc_ready is computed from the registered count only.
REQ-026 When empty, commit_valid SHALL be 0 regardless of commit_ready.
REQ-027 A write-back and an alloc targeting the same index in the same cycle SHALL be handled as follows:
- The write-back is judged against the pre-edge state (FREE), so it is ignored and wb_err is set.
- The alloc proceeds.
REQ-028 Commit order SHALL equal allocation order, whatever the write-back order.

Reset
REQ-029 Reset SHALL act immediately on assertion of rst_n low, independent of clk, and SHALL establish:
- Pointers and count: head=tail=0, count=0.
- Entry state: all entries FREE.
- Status outputs: wb_err=0, flush=0, commit_valid=0.
- Allocation: alloc_ready=1 on the first cycle after release.
- Payload storage: need not be reset; commit outputs still read 0 via REQ-023.

Configuration
REQ-030 When macro ROB_FLUSH_EN is defined, flush behaviour SHALL be as follows:
- On commit of a head entry with flags[7]=1, flush SHALL pulse high on the next cycle.
- All entries SHALL become FREE, tail SHALL be set to head+1 (the new head), and count SHALL become 0.
- alloc_ready SHALL be 0 while commit_valid & commit_flags[7], so that no allocation is lost mid-flush.
- A write-back arriving in the flush cycle SHALL be discarded without setting wb_err.
REQ-031 When ROB_FLUSH_EN is undefined, the flush port SHALL be absent and flags[7] SHALL carry no meaning.

Structure
REQ-032 Shared package rob_pkg SHALL define:
- ROB_DEPTH and ROB_IDX_W.
- Enum rob_state_t {FREE, ISSUED, DONE}.
- Struct rob_entry_t {state, flags, wbs, value}.
REQ-033 There SHALL be no sub-module: the entry array and pointer logic stay inline.

Verification
REQ-034 Reset, then 16 allocs with no write-back -> alloc_robid runs 0..15, count=16, alloc_ready=0, commit_valid=0.
REQ-035 Alloc ids 0,1,2; write-back value 0x33 to id 2, then 0x22 to id 1, then 0x11 to id 0; commit_ready=1 -> commits id0=0x11, id1=0x22, id2=0x33 on consecutive cycles.
REQ-036 Fill to 16, complete the head, then assert alloc_valid and commit_ready in the same cycle -> the commit occurs, the alloc is refused, count=15; on the next cycle alloc_robid=0 after the wrap.
REQ-037 Write-back to a FREE id 5 with value 0xAA -> no state change, wb_err=1 and held; commit outputs stay 0.
REQ-038 With ROB_FLUSH_EN: alloc ids 0..3; write back all four with id1 flags=0x80 -> commits id0 and id1, then flush pulses, count=0, next alloc_robid=2.
